svi_rr_arbiter: RTL and testbench
=================================

SVI_RR_ARBITER -- requirements
Module: svi_rr_arbiter

Interface
REQ-001 Parameter SIZE, default 8: number of requesters sharing the resource; legal range 2..32.
REQ-002 Parameter HOLD_MAX, default 15: maximum cycles a grant may be held without i_done; legal range 1..255.
REQ-003 i_clk  input  1  single clock; every flop updates on its rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_req  input  SIZE  per-requester request, level-sensitive; bit k belongs to requester k.
REQ-006 i_done  input  SIZE  per-requester release strobe; only the bit of the granted requester is honoured.
REQ-007 o_gnt  output  SIZE  registered one-hot grant; all-zero when no requester holds the resource.
REQ-008 o_gnt_idx  output  $clog2(SIZE)  registered index of the granted requester; 0 when o_gnt is all-zero.
REQ-009 o_busy  output  1  registered; high exactly when o_gnt is non-zero.
REQ-010 o_timeout  output  1  registered one-cycle pulse when a grant is revoked for exceeding HOLD_MAX.

Function
REQ-011 FSM states: IDLE (no grant), GRANT (one requester owns the resource), BACKOFF (one-cycle gap after a revoked grant).
REQ-012 IDLE: if i_req is non-zero, pick a winner and go to GRANT; o_gnt, o_gnt_idx and o_busy are valid on the next cycle (1-cycle latency); otherwise stay in IDLE.
REQ-013 Winner selection: round-robin; the first set bit of i_req at or above the priority pointer, wrapping from SIZE-1 to 0.
REQ-014 The priority pointer resets to 0; when a grant is issued to index k, it loads (k+1) mod SIZE.
REQ-015 GRANT: the hold counter resets to 0 on grant entry and increments by 1 per cycle in GRANT, saturating at HOLD_MAX.
REQ-016 GRANT -> IDLE when i_done[idx] = 1 or i_req[idx] = 0; o_gnt clears on the next cycle; o_timeout stays low.
REQ-017 GRANT -> BACKOFF when the hold counter equals HOLD_MAX, i_done[idx] = 0 and i_req[idx] = 1; o_gnt clears and o_timeout pulses for one cycle on the next cycle.
REQ-018 If i_done and the timeout condition occur in the same cycle, i_done wins: no timeout pulse.
REQ-019 BACKOFF lasts exactly one cycle and then goes to IDLE; no grant is issued from BACKOFF.
REQ-020 i_done bits of non-granted requesters, and i_done while in IDLE or BACKOFF, are ignored.
REQ-021 Back-to-back ownership: a new grant appears no earlier than 2 cycles after the releasing i_done; o_gnt is never non-zero for two different indices on consecutive cycles.
REQ-022 o_gnt is always one-hot or zero; o_gnt_idx always matches the set bit of o_gnt.

Reset
REQ-023 While i_rst is high: state = IDLE, pointer = 0, hold counter = 0, o_gnt = 0, o_gnt_idx = 0, o_busy = 0, o_timeout = 0.
REQ-024 If i_rst asserts mid-grant, the grant is dropped on the next edge with no o_timeout pulse; arbitration resumes the cycle after i_rst deasserts.

Structure
REQ-025 A shared package arb_pkg holds the state enum (IDLE, GRANT, BACKOFF) and the default SIZE constant (8).
REQ-026 One sub-module, rr_pick: combinational rotating-priority picker (inputs request vector and pointer; outputs valid and index), instantiated once.
REQ-027 All outputs are driven directly from flops; no combinational path from inputs to outputs.

Verification
REQ-028 Reset, then i_req = 8'b0000_0101 held, with i_done pulsed 3 cycles after each grant -> grants go to index 0, then 2, then 0, with o_gnt = 0 for one cycle between each.
REQ-029 All 8 requests held, each grant released immediately by i_done -> grant order 0,1,2,...,7,0; o_gnt_idx tracks it.
REQ-030 Single request on index 3 held, no i_done, HOLD_MAX = 15 -> o_gnt = 8'b0000_1000 for 16 cycles, then o_gnt = 0 and o_timeout = 1 for one cycle, then BACKOFF, IDLE, and a re-grant to index 3.
REQ-031 i_done[3] asserted in the same cycle the hold counter hits HOLD_MAX -> normal release, o_timeout stays 0.
REQ-032 i_rst pulsed while index 5 is granted -> next cycle o_gnt = 0, o_busy = 0, o_timeout = 0; after release from reset with all requests high, the first grant goes to index 0.
REQ-033 i_done[6] pulsed while index 2 is granted -> ignored, and index 2 keeps the grant.

Source files
------------

// File: rtl/svi_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: state encoding and default sizing.
package arb_pkg;

    localparam int DEFAULT_SIZE = 8;
    localparam int HOLD_W       = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_BACKOFF = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        GRANT   = ST_GRANT,
        BACKOFF = ST_BACKOFF
    } arb_state_e;

endpackage

// File: rtl/svi_rr_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface svi_rr_arbiter_if #(
    parameter int SIZE = 8
);
    localparam int IW = $clog2(SIZE);

    // Handshake: i_req[k] is a level held by requester k until it is done; the
    // arbiter answers with a registered one-hot o_gnt. Ownership ends when the
    // owner pulses i_done[k], drops i_req[k], or holds past the limit (o_timeout).
    logic [SIZE-1:0] i_req;
    logic [SIZE-1:0] i_done;
    logic [SIZE-1:0] o_gnt;
    logic [IW-1:0]   o_gnt_idx;
    logic            o_busy;
    logic            o_timeout;

    modport master (
        output i_req, i_done,
        input  o_gnt, o_gnt_idx, o_busy, o_timeout
    );

    modport slave (
        input  i_req, i_done,
        output o_gnt, o_gnt_idx, o_busy, o_timeout
    );

endinterface

// File: rtl/svi_rr_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or above ptr, wrapping at SIZE-1.
module rr_pick #(
    parameter int SIZE = 8,
    parameter int IW   = $clog2(SIZE)
) (
    input  logic [SIZE-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < SIZE; i++) begin
            // One extra bit so ptr + offset never overflows before the wrap.
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(SIZE)) begin
                sum = sum - (IW+1)'(SIZE);
            end
            cand = sum[IW-1:0];
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/svi_rr_arbiter.sv
// Round-robin arbiter with a per-grant hold limit and a one-cycle backoff after revocation.
module svi_rr_arbiter
    import arb_pkg::*;
#(
    parameter int SIZE     = DEFAULT_SIZE,
    parameter int HOLD_MAX = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    svi_rr_arbiter_if.slave   bus,
    output arb_state_e        o_dbg_state
);

    localparam int                IW       = $clog2(SIZE);
    localparam logic [SIZE-1:0]   ONE      = {{(SIZE-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]     LAST     = IW'(SIZE - 1);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);

    logic [1:0]        state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [SIZE-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;

    logic              pick_valid;
    logic [IW-1:0]     pick_idx;

    rr_pick #(
        .SIZE (SIZE),
        .IW   (IW)
    ) u_pick (
        .req   (bus.i_req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_GRANT;
                    gnt_d   = ONE << pick_idx;
                    idx_d   = pick_idx;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                    ptr_d   = (pick_idx == LAST) ? '0 : pick_idx + IW'(1);
                end
            end
            ST_GRANT: begin
                // A release in the same cycle as the limit wins over the timeout.
                if (bus.i_done[idx_q] || !bus.i_req[idx_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LIM) begin
                    state_d   = ST_BACKOFF;
                    gnt_d     = '0;
                    idx_d     = '0;
                    busy_d    = 1'b0;
                    hold_d    = '0;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_BACKOFF: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                idx_d   = '0;
                busy_d  = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.o_gnt     = gnt_q;
    assign bus.o_gnt_idx = idx_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_timeout = timeout_q;
    assign o_dbg_state   = arb_state_e'(state_q);

endmodule

// File: tb/tb_svi_rr_arbiter.sv
// Bench for svi_rr_arbiter: vector table, directed corner sequences, random run vs. an ownership model.
module tb_svi_rr_arbiter;
    import arb_pkg::*;

    localparam int SIZE     = 8;
    localparam int HOLD_MAX = 15;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    arb_state_e dbg_state;

    always #5 clk = ~clk;

    svi_rr_arbiter_if #(.SIZE(SIZE)) bus ();

    svi_rr_arbiter #(
        .SIZE     (SIZE),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    // Tracks who owns the resource, how long they have held it, the next
    // priority position and whether a post-timeout gap is pending.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    int m_cool  = 0;
    bit m_to    = 1'b0;

    function automatic void model_step(input logic [SIZE-1:0] req,
                                       input logic [SIZE-1:0] done,
                                       input logic r);
        int k;
        if (r) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_cool = 0; m_to = 1'b0;
        end else if (m_owner >= 0) begin
            m_to = 1'b0;
            if (done[m_owner] || !req[m_owner]) begin
                m_owner = -1;
            end else if (m_held == HOLD_MAX) begin
                m_owner = -1; m_to = 1'b1; m_cool = 1;
            end else begin
                m_held++;
            end
        end else if (m_cool != 0) begin
            m_cool = 0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            for (int n = 0; n < SIZE; n++) begin
                k = (m_ptr + n) % SIZE;
                if (req[k]) begin
                    m_owner = k; m_held = 0; m_ptr = (k + 1) % SIZE;
                    break;
                end
            end
        end
    endfunction

    // ---------------- driver / checker ----------------
    task automatic apply(input logic [SIZE-1:0] req, input logic [SIZE-1:0] done,
                         input logic r);
        bus.i_req  = req;
        bus.i_done = done;
        rst        = r;
        @(posedge clk);
        model_step(req, done, r);
        #1;
    endtask

    task automatic check(input string name, input logic [SIZE-1:0] e_gnt,
                         input logic [2:0] e_idx, input logic e_busy, input logic e_to);
        vectors++;
        if (bus.o_gnt !== e_gnt || bus.o_gnt_idx !== e_idx ||
            bus.o_busy !== e_busy || bus.o_timeout !== e_to) begin
            miscompares++;
            $display("FAIL %s @%0t: got gnt=%h idx=%0d busy=%b to=%b, want gnt=%h idx=%0d busy=%b to=%b",
                     name, $time, bus.o_gnt, bus.o_gnt_idx, bus.o_busy, bus.o_timeout,
                     e_gnt, e_idx, e_busy, e_to);
        end
    endtask

    task automatic check_model(input string name);
        logic [SIZE-1:0] g;
        logic [2:0]      ix;
        g  = (m_owner >= 0) ? (SIZE'(1) << m_owner) : '0;
        ix = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        check(name, g, ix, m_owner >= 0, m_to);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [SIZE-1:0] req;
        logic [SIZE-1:0] done;
        logic            rst;
        logic [SIZE-1:0] gnt;
        logic [2:0]      idx;
        logic            busy;
        logic            to;
    } vec_t;

    vec_t tbl[15];
    int   order[3];

    initial begin
        logic [SIZE-1:0] r_req;
        logic [SIZE-1:0] r_done;
        logic            r_rst;

        bus.i_req  = '0;
        bus.i_done = '0;
        rst        = 1'b1;

        tbl[0]  = '{8'h00, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{8'h04, 8'h00, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
        tbl[2]  = '{8'h04, 8'h40, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0}; // foreign done ignored
        tbl[3]  = '{8'h04, 8'h04, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[4]  = '{8'h24, 8'h00, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
        tbl[5]  = '{8'h24, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0}; // reset mid-grant
        tbl[6]  = '{8'hFF, 8'h00, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
        tbl[7]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[8]  = '{8'hFF, 8'h00, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0};
        tbl[9]  = '{8'h00, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0}; // request drop releases
        tbl[10] = '{8'h00, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[11] = '{8'h80, 8'h00, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
        tbl[12] = '{8'h80, 8'h80, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[13] = '{8'h81, 8'h00, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0}; // wrap to 0
        tbl[14] = '{8'h00, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};

        #1;
        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].req, tbl[i].done, tbl[i].rst);
            check($sformatf("table[%0d]", i), tbl[i].gnt, tbl[i].idx, tbl[i].busy, tbl[i].to);
        end

        // Two requesters alternate, done three cycles into each grant.
        order = '{0, 2, 0};
        apply('0, '0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            apply(8'h05, '0, 1'b0);
            check("alt_grant", SIZE'(1) << order[k], 3'(order[k]), 1'b1, 1'b0);
            apply(8'h05, '0, 1'b0);
            check_model("alt_hold");
            apply(8'h05, '0, 1'b0);
            check_model("alt_hold");
            apply(8'h05, SIZE'(1) << order[k], 1'b0);
            check("alt_release", '0, 3'd0, 1'b0, 1'b0);
        end

        // Everyone requesting, immediate release: strict rotation.
        apply('0, '0, 1'b1);
        for (int k = 0; k <= SIZE; k++) begin
            apply(8'hFF, '0, 1'b0);
            check("rotate_grant", SIZE'(1) << (k % SIZE), 3'(k % SIZE), 1'b1, 1'b0);
            apply(8'hFF, SIZE'(1) << (k % SIZE), 1'b0);
            check("rotate_release", '0, 3'd0, 1'b0, 1'b0);
        end

        // Lone holder exceeds the limit: 16 grant cycles, timeout, gap, re-grant.
        apply('0, '0, 1'b1);
        for (int k = 0; k <= HOLD_MAX; k++) begin
            apply(8'h08, '0, 1'b0);
            check("hold_grant", 8'h08, 3'd3, 1'b1, 1'b0);
        end
        apply(8'h08, '0, 1'b0);
        check("timeout_pulse", '0, 3'd0, 1'b0, 1'b1);
        apply(8'h08, '0, 1'b0);
        check("backoff_gap", '0, 3'd0, 1'b0, 1'b0);
        apply(8'h08, '0, 1'b0);
        check("regrant", 8'h08, 3'd3, 1'b1, 1'b0);

        // Release on the very cycle the limit is reached: no timeout.
        apply('0, '0, 1'b1);
        for (int k = 0; k <= HOLD_MAX; k++) begin
            apply(8'h08, '0, 1'b0);
            check("limit_grant", 8'h08, 3'd3, 1'b1, 1'b0);
        end
        apply(8'h08, 8'h08, 1'b0);
        check("done_beats_timeout", '0, 3'd0, 1'b0, 1'b0);
        apply(8'h08, '0, 1'b0);
        check("after_done", 8'h08, 3'd3, 1'b1, 1'b0);

        // Random traffic: a churny phase and a sticky phase that reaches timeouts.
        apply('0, '0, 1'b1);
        r_req = '0;
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 2000; c++) begin
                if ($urandom_range(0, (p == 0) ? 7 : 63) == 0) r_req = SIZE'($urandom);
                r_done = '0;
                if ($urandom_range(0, (p == 0) ? 5 : 40) == 0) begin
                    r_done = ($urandom_range(0, 1) == 1) ? (SIZE'(1) << $urandom_range(0, SIZE-1))
                                                         : SIZE'($urandom);
                end
                r_rst = ($urandom_range(0, 199) == 0);
                apply(r_req, r_done, r_rst);
                check_model("random");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
